// File: rtl/uart_rx_frame_timer.sv
// UART-RX bit/edge timing generator: per-bit oversampling edge counter, per-frame bit counter,
// 3-point sample strobes and bit/frame end pulses. Optional macro: UART_RX_TIMER_CFG_CHECK_EN.
module uart_rx_frame_timer #(
    parameter int PRESCALE_W = 6,
    parameter int DATA_MAX   = 8,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [3:0]            data_bits,
    input  logic                  par_en,
    input  logic                  stop2,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sample_stb,
    output logic                  bit_end,
    output logic                  frame_end,
    output logic                  busy
`ifdef UART_RX_TIMER_CFG_CHECK_EN
    ,
    output logic                  cfg_err
`endif
);

    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);
    localparam logic [3:0]            D_MIN = 4'd5;
    localparam logic [3:0]            D_MAX = 4'(DATA_MAX);

    // IDLE: counters cleared; RUN: timing active; ERR: bad config held until enable drops.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PRESCALE_W-1:0] prescale_lat;
    logic [3:0]            data_lat;
    logic                  par_lat;
    logic                  stop2_lat;

    logic [PRESCALE_W-1:0] prescale_clamp;
    logic [3:0]            data_clamp;
    logic                  cfg_bad;
    logic                  latch_cfg;

    logic [BIT_CNT_W-1:0]  n_last;
    logic [PRESCALE_W-1:0] end_edge;
    logic [PRESCALE_W-1:0] mid_edge;
    logic                  running;

    assign prescale_clamp = (prescale < P_MIN) ? P_MIN : prescale;
    assign data_clamp     = (data_bits < D_MIN) ? D_MIN :
                            (data_bits > D_MAX) ? D_MAX : data_bits;

`ifdef UART_RX_TIMER_CFG_CHECK_EN
    assign cfg_bad = (prescale < P_MIN) || prescale[0] ||
                     (data_bits < D_MIN) || (data_bits > D_MAX);
    assign cfg_err = (state == ERR);
`else
    assign cfg_bad = 1'b0;
`endif

    assign latch_cfg = (state == IDLE) && enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = cfg_bad ? ERR : RUN;
            RUN:     if (!enable) state_nxt = IDLE;
            ERR:     if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_lat <= P_MIN;
            data_lat     <= 4'd8;
            par_lat      <= 1'b0;
            stop2_lat    <= 1'b0;
        end else if (latch_cfg) begin
            prescale_lat <= prescale_clamp;
            data_lat     <= data_clamp;
            par_lat      <= par_en;
            stop2_lat    <= stop2;
        end
    end

    // The start bit is one edge short to absorb the start-detect latency of the RX FSM.
    assign n_last   = BIT_CNT_W'(data_lat) + BIT_CNT_W'(par_lat) +
                      (stop2_lat ? BIT_CNT_W'(2) : BIT_CNT_W'(1));
    assign end_edge = (bit_cnt == '0) ? prescale_lat - PRESCALE_W'(2)
                                      : prescale_lat - PRESCALE_W'(1);
    assign mid_edge = (bit_cnt == '0) ? (prescale_lat >> 1) - PRESCALE_W'(1)
                                      : (prescale_lat >> 1);
    assign running  = (state == RUN) && enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt  <= '0;
            edge_cnt <= '0;
        end else if (!running) begin
            bit_cnt  <= '0;
            edge_cnt <= '0;
        end else if (edge_cnt == end_edge) begin
            edge_cnt <= '0;
            bit_cnt  <= (bit_cnt == n_last) ? '0 : bit_cnt + BIT_CNT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + PRESCALE_W'(1);
        end
    end

    assign busy       = (state == RUN);
    assign sample_stb = running && ((edge_cnt == mid_edge - PRESCALE_W'(1)) ||
                                    (edge_cnt == mid_edge) ||
                                    (edge_cnt == mid_edge + PRESCALE_W'(1)));
    assign bit_end    = running && (edge_cnt == end_edge);
    assign frame_end  = bit_end && (bit_cnt == n_last);

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// Directed bench for uart_rx_frame_timer: walks whole frames edge by edge against hand-derived timing.
module tb_uart_rx_frame_timer;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [5:0] prescale;
    logic [3:0] data_bits;
    logic       par_en;
    logic       stop2;
    logic [3:0] bit_cnt;
    logic [5:0] edge_cnt;
    logic       sample_stb;
    logic       bit_end;
    logic       frame_end;
    logic       busy;
`ifdef UART_RX_TIMER_CFG_CHECK_EN
    logic       cfg_err;
`endif

    int n_checks = 0;
    int n_bad    = 0;

    uart_rx_frame_timer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .prescale   (prescale),
        .data_bits  (data_bits),
        .par_en     (par_en),
        .stop2      (stop2),
        .bit_cnt    (bit_cnt),
        .edge_cnt   (edge_cnt),
        .sample_stb (sample_stb),
        .bit_end    (bit_end),
        .frame_end  (frame_end),
        .busy       (busy)
`ifdef UART_RX_TIMER_CFG_CHECK_EN
        ,
        .cfg_err    (cfg_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check_val({tag, " busy"},  int'(busy), 0);
        check_val({tag, " bit"},   int'(bit_cnt), 0);
        check_val({tag, " edge"},  int'(edge_cnt), 0);
        check_val({tag, " stb"},   int'(sample_stb), 0);
        check_val({tag, " bend"},  int'(bit_end), 0);
        check_val({tag, " fend"},  int'(frame_end), 0);
    endtask

    task automatic start_frame(input int p, input int d, input bit par, input bit s2);
        prescale  = 6'(p);
        data_bits = 4'(d);
        par_en    = par;
        stop2     = s2;
        enable    = 1'b1;
        step();
    endtask

    task automatic stop_frame(input string tag);
        enable = 1'b0;
        step();
        expect_idle(tag);
    endtask

    // Expected timing: start bit p-1 edges with centre p/2-1, other bits p edges with centre p/2.
    task automatic walk_frame(input string tag, input int p, input int n);
        int len;
        int mid;
        for (int b = 0; b < n; b++) begin
            len = (b == 0) ? p - 1 : p;
            mid = (b == 0) ? p / 2 - 1 : p / 2;
            for (int e = 0; e < len; e++) begin
                check_val({tag, " busy"}, int'(busy), 1);
                check_val({tag, " bit"},  int'(bit_cnt), b);
                check_val({tag, " edge"}, int'(edge_cnt), e);
                check_val({tag, " stb"},  int'(sample_stb), int'(e >= mid - 1 && e <= mid + 1));
                check_val({tag, " bend"}, int'(bit_end), int'(e == len - 1));
                check_val({tag, " fend"}, int'(frame_end), int'(e == len - 1 && b == n - 1));
                step();
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        prescale  = 6'd8;
        data_bits = 4'd8;
        par_en    = 1'b0;
        stop2     = 1'b0;
        repeat (3) step();
        expect_idle("reset");
        reset_n = 1'b1;
        step();
        expect_idle("post_reset");

        // 8N1, P=8: 79 cycles then wrap back to bit 0 edge 0
        start_frame(8, 8, 1'b0, 1'b0);
        walk_frame("t1", 8, 10);
        check_val("t1 wrap bit", int'(bit_cnt), 0);
        check_val("t1 wrap edge", int'(edge_cnt), 0);
        check_val("t1 wrap busy", int'(busy), 1);
        stop_frame("t1 stop");

        // P=16, 7 data, parity, 2 stop: N=11
        start_frame(16, 7, 1'b1, 1'b1);
        walk_frame("t2", 16, 11);
        stop_frame("t2 stop");

        // abort at bit 4 edge 3 (a sample edge)
        start_frame(8, 8, 1'b0, 1'b0);
        repeat (34) step();
        check_val("t3 bit", int'(bit_cnt), 4);
        check_val("t3 edge", int'(edge_cnt), 3);
        check_val("t3 stb pre", int'(sample_stb), 1);
        enable = 1'b0;
        #1;
        check_val("t3 stb gated", int'(sample_stb), 0);
        check_val("t3 fend gated", int'(frame_end), 0);
        step();
        expect_idle("t3 abort");

        // prescale changed after latch is ignored until re-enable
        start_frame(8, 8, 1'b0, 1'b0);
        prescale = 6'd16;
        walk_frame("t4a", 8, 10);
        stop_frame("t4 stop");
        enable = 1'b1;
        step();
        walk_frame("t4b", 16, 10);
        stop_frame("t4b stop");

        // back-to-back 5N1, P=4: 27-cycle frames, no gap
        start_frame(4, 5, 1'b0, 1'b0);
        walk_frame("t5f0", 4, 7);
        walk_frame("t5f1", 4, 7);
        walk_frame("t5f2", 4, 7);
        stop_frame("t5 stop");

`ifdef UART_RX_TIMER_CFG_CHECK_EN
        start_frame(3, 8, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check_val("t6 cfg_err", int'(cfg_err), 1);
            expect_idle("t6 err");
            step();
        end
        enable = 1'b0;
        step();
        check_val("t6 cfg_err clr", int'(cfg_err), 0);
        start_frame(5, 8, 1'b0, 1'b0);
        check_val("t6 odd err", int'(cfg_err), 1);
        stop_frame("t6 odd stop");
        start_frame(8, 3, 1'b0, 1'b0);
        check_val("t6 data err", int'(cfg_err), 1);
        stop_frame("t6 data stop");
        start_frame(4, 5, 1'b0, 1'b0);
        check_val("t6 ok err", int'(cfg_err), 0);
        walk_frame("t6 ok", 4, 7);
        stop_frame("t6 ok stop");
`else
        // P=3 clamps to 4; data_bits clamps to 5..8; odd P accepted
        start_frame(3, 8, 1'b0, 1'b0);
        walk_frame("t6 p3", 4, 10);
        stop_frame("t6 p3 stop");
        start_frame(4, 3, 1'b0, 1'b0);
        walk_frame("t6 d3", 4, 7);
        stop_frame("t6 d3 stop");
        start_frame(4, 15, 1'b1, 1'b0);
        walk_frame("t6 d15", 4, 11);
        stop_frame("t6 d15 stop");
        start_frame(5, 8, 1'b0, 1'b0);
        walk_frame("t6 p5", 5, 10);
        stop_frame("t6 p5 stop");
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
